sfp_link_ctrl: RTL and testbench

SFP_LINK_CTRL -- requirements
Module: sfp_link_ctrl

---
 rtl/sfp_link_ctrl_if.sv | 25 ++
 rtl/sfp_link_ctrl.sv | 167 ++++++++++++++++
 tb/tb_sfp_link_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/sfp_link_ctrl_if.sv
// Link-controller signal bundle: enable and PHY/GT status in, GT reset requests and status out.
interface sfp_link_ctrl_if;
  logic       enable;
  logic       gt_reset_tx_done;
  logic       gt_reset_rx_done;
  logic       rx_block_lock;
  logic       rx_high_ber;
  logic       gt_reset_all;
  logic       gt_reset_rx_datapath;
  logic       link_up;
  logic [2:0] state;
  logic [7:0] retry_count;

  // Drives enable and the status inputs; observes the controller outputs.
  modport master (
    output enable, gt_reset_tx_done, gt_reset_rx_done, rx_block_lock, rx_high_ber,
    input  gt_reset_all, gt_reset_rx_datapath, link_up, state, retry_count
  );

  // The link controller itself.
  modport slave (
    input  enable, gt_reset_tx_done, gt_reset_rx_done, rx_block_lock, rx_high_ber,
    output gt_reset_all, gt_reset_rx_datapath, link_up, state, retry_count
  );
endinterface

// File: rtl/sfp_link_ctrl.sv
// SFP/10GBASE-R link bring-up controller: sequences GT full and RX-datapath resets, waits for
// reset-done and block lock, debounces lock, and recovers from lock loss, high BER or TX loss.
module sfp_link_ctrl #(
  parameter int unsigned RESET_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT    = 1250000,
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter int unsigned CNT_WIDTH       = 24
) (
  input logic            clk,
  input logic            rst,
  sfp_link_ctrl_if.slave link
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StGtReset   = 3'd1,
    StWaitTx    = 3'd2,
    StWaitRx    = 3'd3,
    StWaitLock  = 3'd4,
    StDebounce  = 3'd5,
    StLinkUp    = 3'd6,
    StRxReset   = 3'd7
  } state_e;

  localparam logic [CNT_WIDTH-1:0] ResetLast    = CNT_WIDTH'(RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TimeoutLast  = CNT_WIDTH'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] DebounceLast = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  // Bit order: {high_ber, lock, rx_done, tx_done}
  logic [3:0] async_in;
  logic [3:0] sync1_q, sync2_q;
  logic       tx_done, rx_done, lock, high_ber;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   timer_q, timer_d;
  logic [7:0]             retry_q, retry_d;
  logic                   retry_inc;
  logic                   gt_reset_all_q, gt_reset_rx_datapath_q, link_up_q;

  assign async_in = {link.rx_high_ber, link.rx_block_lock, link.gt_reset_rx_done,
                     link.gt_reset_tx_done};
  assign tx_done  = sync2_q[0];
  assign rx_done  = sync2_q[1];
  assign lock     = sync2_q[2];
  assign high_ber = sync2_q[3];

  // Two-flop synchronizers for the asynchronous status inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
    end
  end

  // Next-state and retry decision; enable loss beats TX loss beats per-state conditions.
  always_comb begin
    state_d   = state_q;
    retry_inc = 1'b0;
    case (state_q)
      StIdle: begin
        if (link.enable) state_d = StGtReset;
      end
      StGtReset: begin
        if (timer_q == ResetLast) state_d = StWaitTx;
      end
      StWaitTx: begin
        if (tx_done) begin
          state_d = StWaitRx;
        end else if (timer_q == TimeoutLast) begin
          state_d   = StGtReset;
          retry_inc = 1'b1;
        end
      end
      StWaitRx: begin
        if (rx_done) begin
          state_d = StWaitLock;
        end else if (timer_q == TimeoutLast) begin
          state_d   = StGtReset;
          retry_inc = 1'b1;
        end
      end
      StWaitLock: begin
        if (lock) begin
          state_d = StDebounce;
        end else if (timer_q == TimeoutLast) begin
          state_d   = StRxReset;
          retry_inc = 1'b1;
        end
      end
      StDebounce: begin
        // A lock glitch restarts the wait but is not counted as a recovery attempt.
        if (!lock) begin
          state_d = StWaitLock;
        end else if (timer_q == DebounceLast) begin
          state_d = StLinkUp;
        end
      end
      StLinkUp: begin
        if (!lock || high_ber) begin
          state_d   = StRxReset;
          retry_inc = 1'b1;
        end
      end
      StRxReset: begin
        if (timer_q == ResetLast) state_d = StWaitRx;
      end
      default: state_d = StIdle;
    endcase

    // Once TX is up, losing it forces a full GT reset from any later state.
    if (!tx_done && (state_q inside {StWaitRx, StWaitLock, StDebounce, StLinkUp, StRxReset}))
    begin
      state_d   = StGtReset;
      retry_inc = 1'b1;
    end

    if (!link.enable) begin
      state_d   = StIdle;
      retry_inc = 1'b0;
    end
  end

  // Shared timer restarts on every state change and otherwise counts up, saturating.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_q != '1) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Saturating recovery-attempt counter.
  always_comb begin
    retry_d = retry_q;
    if (retry_inc && (retry_q != 8'hFF)) retry_d = retry_q + 8'd1;
  end

  // State, timer, counter and outputs; outputs decode state_d so they switch on state entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q                <= StIdle;
      timer_q                <= '0;
      retry_q                <= '0;
      gt_reset_all_q         <= 1'b0;
      gt_reset_rx_datapath_q <= 1'b0;
      link_up_q              <= 1'b0;
    end else begin
      state_q                <= state_d;
      timer_q                <= timer_d;
      retry_q                <= retry_d;
      gt_reset_all_q         <= (state_d == StGtReset);
      gt_reset_rx_datapath_q <= (state_d == StRxReset);
      link_up_q              <= (state_d == StLinkUp);
    end
  end

  assign link.state                = state_q;
  assign link.retry_count          = retry_q;
  assign link.gt_reset_all         = gt_reset_all_q;
  assign link.gt_reset_rx_datapath = gt_reset_rx_datapath_q;
  assign link.link_up              = link_up_q;

endmodule

// File: tb/tb_sfp_link_ctrl.sv
// Scoreboard bench for sfp_link_ctrl: stimulus pushes expected output changes (cycle stamp and
// output tuple) into a queue; a negedge monitor pops one entry per observed output change.
module tb_sfp_link_ctrl;

  localparam int SIdle = 0, SGtReset = 1, SWaitTx = 2, SWaitRx = 3;
  localparam int SWaitLock = 4, SDebounce = 5, SLinkUp = 6, SRxReset = 7;

  typedef struct packed {
    logic [2:0] st;
    logic       gra;
    logic       rxdp;
    logic       lu;
    logic [7:0] rc;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t obs;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_errors;
  obs_t prev;
  exp_t q[$];

  sfp_link_ctrl_if link ();

  sfp_link_ctrl #(
    .RESET_CYCLES   (4),
    .LOCK_TIMEOUT   (100),
    .DEBOUNCE_CYCLES(8),
    .CNT_WIDTH      (24)
  ) dut (
    .clk (clk),
    .rst (rst),
    .link(link)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t sample();
    obs_t o;
    o = {link.state, link.gt_reset_all, link.gt_reset_rx_datapath, link.link_up,
         link.retry_count};
    return o;
  endfunction

  task automatic push(input int at, input int st, input logic gra, input logic rxdp,
                      input logic lu, input int rc);
    exp_t e;
    logic [7:0] rc8;
    logic [2:0] st3;
    rc8 = rc[7:0];
    st3 = st[2:0];
    e.cyc = at;
    e.obs = {st3, gra, rxdp, lu, rc8};
    q.push_back(e);
  endtask

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, want);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, int'(link.state), 0);
    check({tag, "_gt_reset_all"}, int'(link.gt_reset_all), 0);
    check({tag, "_gt_reset_rx_datapath"}, int'(link.gt_reset_rx_datapath), 0);
    check({tag, "_link_up"}, int'(link.link_up), 0);
    check({tag, "_retry_count"}, int'(link.retry_count), 0);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Assert rst mid-cycle (no clk edge) and confirm outputs drop immediately.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #2 rst = 1'b1;
    push(cyc, SIdle, 1'b0, 1'b0, 1'b0, 0);
    #1;
    check_all_zero(tag);
  endtask

  // Monitor: every change of the output tuple must match the next expected event.
  always @(negedge clk) begin
    obs_t cur;
    exp_t e;
    cur = sample();
    if (cur != prev) begin
      n_checks++;
      if (q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_change cyc=%0d got st=%0d gra=%0d rxdp=%0d lu=%0d rc=%0d",
                 cyc, cur.st, cur.gra, cur.rxdp, cur.lu, cur.rc);
      end else begin
        e = q.pop_front();
        if ((e.cyc != cyc) || (e.obs != cur)) begin
          n_errors++;
          $display({"FAIL event got cyc=%0d st=%0d gra=%0d rxdp=%0d lu=%0d rc=%0d ",
                    "required cyc=%0d st=%0d gra=%0d rxdp=%0d lu=%0d rc=%0d"},
                   cyc, cur.st, cur.gra, cur.rxdp, cur.lu, cur.rc,
                   e.cyc, e.obs.st, e.obs.gra, e.obs.rxdp, e.obs.lu, e.obs.rc);
        end
      end
      prev = cur;
    end
  end

  initial begin
    int t0, tb, tc, td, te, tf, tg, rc;
    n_checks = 0;
    n_errors = 0;
    prev     = '0;
    rst      = 1'b1;
    link.enable           = 1'b0;
    link.gt_reset_tx_done = 1'b0;
    link.gt_reset_rx_done = 1'b0;
    link.rx_block_lock    = 1'b0;
    link.rx_high_ber      = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");

    // Nominal bring-up: 4-cycle GT reset, then tx/rx/lock staggered, 8-cycle debounce
    rst = 1'b0;
    link.enable = 1'b1;
    t0 = cyc;
    push(t0 + 1,  SGtReset,  1'b1, 1'b0, 1'b0, 0);
    push(t0 + 5,  SWaitTx,   1'b0, 1'b0, 1'b0, 0);
    push(t0 + 18, SWaitRx,   1'b0, 1'b0, 1'b0, 0);
    push(t0 + 23, SWaitLock, 1'b0, 1'b0, 1'b0, 0);
    push(t0 + 28, SDebounce, 1'b0, 1'b0, 1'b0, 0);
    push(t0 + 36, SLinkUp,   1'b0, 1'b0, 1'b1, 0);
    wait_until(t0 + 15);
    link.gt_reset_tx_done = 1'b1;
    wait_until(t0 + 20);
    link.gt_reset_rx_done = 1'b1;
    wait_until(t0 + 25);
    link.rx_block_lock = 1'b1;
    wait_until(t0 + 40);

    // Async reset from LINK_UP, then lock timeout with tx/rx done but no lock
    async_reset("rst_linkup");
    link.rx_block_lock = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tb = cyc;
    push(tb + 1,   SGtReset,  1'b1, 1'b0, 1'b0, 0);
    push(tb + 5,   SWaitTx,   1'b0, 1'b0, 1'b0, 0);
    push(tb + 6,   SWaitRx,   1'b0, 1'b0, 1'b0, 0);
    push(tb + 7,   SWaitLock, 1'b0, 1'b0, 1'b0, 0);
    push(tb + 107, SRxReset,  1'b0, 1'b1, 1'b0, 1);
    push(tb + 111, SWaitRx,   1'b0, 1'b0, 1'b0, 1);
    push(tb + 112, SWaitLock, 1'b0, 1'b0, 1'b0, 1);

    // Debounce glitch: lock 5 high, 1 low, then high
    wait_until(tb + 115);
    tc = cyc;
    link.rx_block_lock = 1'b1;
    push(tc + 3,  SDebounce, 1'b0, 1'b0, 1'b0, 1);
    push(tc + 8,  SWaitLock, 1'b0, 1'b0, 1'b0, 1);
    push(tc + 9,  SDebounce, 1'b0, 1'b0, 1'b0, 1);
    push(tc + 17, SLinkUp,   1'b0, 1'b0, 1'b1, 1);
    wait_until(tc + 5);
    link.rx_block_lock = 1'b0;
    wait_until(tc + 6);
    link.rx_block_lock = 1'b1;

    // Link loss by 3-cycle high-BER pulse
    wait_until(tc + 20);
    td = cyc;
    link.rx_high_ber = 1'b1;
    push(td + 3,  SRxReset,  1'b0, 1'b1, 1'b0, 2);
    push(td + 7,  SWaitRx,   1'b0, 1'b0, 1'b0, 2);
    push(td + 8,  SWaitLock, 1'b0, 1'b0, 1'b0, 2);
    push(td + 9,  SDebounce, 1'b0, 1'b0, 1'b0, 2);
    push(td + 17, SLinkUp,   1'b0, 1'b0, 1'b1, 2);
    wait_until(td + 3);
    link.rx_high_ber = 1'b0;

    // Enable drop: IDLE next edge, retry held, then full re-bring-up
    wait_until(td + 20);
    te = cyc;
    link.enable = 1'b0;
    push(te + 1,  SIdle,     1'b0, 1'b0, 1'b0, 2);
    push(te + 4,  SGtReset,  1'b1, 1'b0, 1'b0, 2);
    push(te + 8,  SWaitTx,   1'b0, 1'b0, 1'b0, 2);
    push(te + 9,  SWaitRx,   1'b0, 1'b0, 1'b0, 2);
    push(te + 10, SWaitLock, 1'b0, 1'b0, 1'b0, 2);
    push(te + 11, SDebounce, 1'b0, 1'b0, 1'b0, 2);
    push(te + 19, SLinkUp,   1'b0, 1'b0, 1'b1, 2);
    wait_until(te + 3);
    link.enable = 1'b1;

    // TX loss from LINK_UP, then repeated WAIT_TX timeouts until retry saturates
    wait_until(te + 22);
    tf = cyc;
    link.gt_reset_tx_done = 1'b0;
    for (int k = 0; k <= 301; k++) begin
      rc = (3 + k > 255) ? 255 : 3 + k;
      push(tf + 3 + 104 * k, SGtReset, 1'b1, 1'b0, 1'b0, rc);
      if (k <= 300) push(tf + 7 + 104 * k, SWaitTx, 1'b0, 1'b0, 1'b0, rc);
    end
    tg = tf + 3 + 104 * 301;
    wait_until(tg);

    // Async reset during the 2nd GT_RESET cycle, then release with enable low
    async_reset("rst_gtreset");
    link.enable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tg = cyc;
    wait_until(tg + 10);
    check_all_zero("idle_disabled");
    check("pending_events", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
